// File: rtl/fadd_e4m3_arbiter.sv
// Round-robin arbiter sharing one e4m3 adder among NUM_REQ valid/ready requesters.
// Optional FADD_ARB_STATS_EN adds a saturating completed-op counter (op_count).

// E4M3 (OCP fn variant) adder: round-to-nearest-even, NaN in -> 0x7F, overflow saturates to +/-448.
module float_adder_e4m3 #(
    parameter int LATENCY = 1
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       clock,
    output logic [7:0] y
);
    // Fixed-point image of an operand in units of 2^-9, the smallest subnormal.
    function automatic logic [18:0] to_fix(input logic [7:0] x);
        logic [3:0] m;
        m = (x[6:3] == 4'd0) ? {1'b0, x[2:0]} : {1'b1, x[2:0]};
        return 19'(m) << ((x[6:3] == 4'd0) ? 4'd0 : x[6:3] - 4'd1);
    endfunction

    logic [18:0] fa, fb, mag, rem, half;
    logic        sgn, rnd;
    logic [4:0]  lead, shift, shift_n, q, q_r, ef;
    logic [7:0]  y_c;

    always_comb begin
        fa = to_fix(a);
        fb = to_fix(b);
        if (a[7] == b[7]) begin
            mag = fa + fb;
            sgn = a[7];
        end else if (fa >= fb) begin
            mag = fa - fb;
            sgn = a[7];
        end else begin
            mag = fb - fa;
            sgn = b[7];
        end
        lead = 5'd0;
        for (int i = 0; i < 19; i++) begin
            if (mag[i]) lead = 5'(i);
        end
        // Keep four significant bits (1.xxx), round the rest to nearest-even.
        shift   = (lead > 5'd3) ? lead - 5'd3 : 5'd0;
        q       = 5'(mag >> shift);
        rem     = mag & ((19'd1 << shift) - 19'd1);
        half    = (shift == 5'd0) ? 19'd0 : 19'd1 << (shift - 5'd1);
        rnd     = (shift != 5'd0) && ((rem > half) || ((rem == half) && q[0]));
        q_r     = q + 5'(rnd);
        shift_n = shift;
        if (q_r == 5'd16) begin
            q_r     = 5'd8;
            shift_n = shift + 5'd1;
        end
        ef = q_r[3] ? shift_n + 5'd1 : 5'd0;
        if ((&a[6:0]) || (&b[6:0])) y_c = 8'h7F;
        else if (mag == 19'd0) y_c = {a[7] & b[7], 7'h00};
        else if ((ef > 5'd15) || ((ef == 5'd15) && (q_r[2:0] == 3'd7))) y_c = {sgn, 7'h7E};
        else y_c = {sgn, ef[3:0], q_r[2:0]};
    end

    generate
        if (LATENCY <= 1) begin : g_comb
            logic unused_clock;
            assign unused_clock = clock;
            assign y = y_c;
        end else begin : g_pipe
            logic [7:0] pipe [LATENCY-1];
            always_ff @(posedge clock) begin
                pipe[0] <= y_c;
                for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign y = pipe[LATENCY-2];
        end
    endgenerate
endmodule

// Handshakes: a transfer happens on a posedge where valid && ready; the sender holds its
// payload stable while valid is high and ready is low, and may drop valid only before grant.
module fadd_e4m3_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = 1,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_data,
    output logic [ID_W-1:0]      resp_id
`ifdef FADD_ARB_STATS_EN
    ,
    output logic [15:0]          op_count
`endif
);
    localparam int CNT_W = $clog2(ADDER_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, id_q, grant_id;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         op_a_q, op_b_q, adder_y;
    logic [NUM_REQ-1:0] grant;
    logic               req_hs, resp_hs;

    // Rotating priority: search upward from the requester after the last grantee.
    always_comb begin
        int idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last_grant_q) + 1 + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

    assign req_ready  = (state_q == IDLE && reset_n) ? grant : '0;
    assign resp_valid = (state_q == RESP);
    assign req_hs     = |(req_valid & req_ready);
    assign resp_hs    = resp_valid && resp_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q       <= 8'h00;
            op_b_q       <= 8'h00;
            id_q         <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            resp_data    <= 8'h00;
            resp_id      <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_hs) begin
                    op_a_q       <= req_a[8*grant_id +: 8];
                    op_b_q       <= req_b[8*grant_id +: 8];
                    id_q         <= grant_id;
                    last_grant_q <= grant_id;
                    cnt_q        <= CNT_W'(ADDER_LATENCY - 1);
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        resp_data <= adder_y;
                        resp_id   <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    float_adder_e4m3 #(.LATENCY(ADDER_LATENCY)) u_adder (
        .a     (op_a_q),
        .b     (op_b_q),
        .clock (clock),
        .y     (adder_y)
    );

`ifdef FADD_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          op_count <= 16'h0000;
        else if (resp_hs && op_count != 16'hFFFF) op_count <= op_count + 16'h0001;
    end
`else
    logic unused_resp_hs;
    assign unused_resp_hs = resp_hs;
`endif
endmodule

// File: tb/tb_fadd_e4m3_arbiter.sv
// Scoreboard bench for fadd_e4m3_arbiter: real-valued e4m3 reference, round-robin model,
// directed phases (reset, single op, rotation, backpressure, reset mid-op) then random traffic.
module tb_fadd_e4m3_arbiter;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a = '0, req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [7:0]     resp_data;
    logic [IDW-1:0] resp_id;
`ifdef FADD_ARB_STATS_EN
    logic [15:0]    op_count;
`endif

    fadd_e4m3_arbiter #(.NUM_REQ(N), .ADDER_LATENCY(LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef FADD_ARB_STATS_EN
        ,
        .op_count   (op_count)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [IDW+7:0] exp_q[$];
    int             due_q[$];
    int             grant_log[$];
    logic [IDW+7:0] resp_log[$];
    logic           model_busy = 1'b0;
    int             model_last = N - 1;
    logic [N-1:0]   hs_mask = '0;
    logic           prev_rv = 1'b0;
    logic [15:0]    stat_exp = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real e4m3_mag(input logic [7:0] x);
        int e = int'(x[6:3]);
        int m = int'(x[2:0]);
        if (e == 0) return real'(m) / 8.0 * pow2(-6);
        return (1.0 + real'(m) / 8.0) * pow2(e - 7);
    endfunction

    function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
        real va, vb, r, mag, d, bestd;
        logic [7:0] best;
        if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) return 8'h7F;
        va = a[7] ? -e4m3_mag(a) : e4m3_mag(a);
        vb = b[7] ? -e4m3_mag(b) : e4m3_mag(b);
        r  = va + vb;
        if (r == 0.0) return {a[7] & b[7], 7'h00};
        mag   = (r < 0.0) ? -r : r;
        best  = 8'h00;
        bestd = 1.0e9;
        // Nearest finite code, ties to the even code; large sums land on 448.
        for (int c = 0; c < 127; c++) begin
            d = e4m3_mag(8'(c)) - mag;
            if (d < 0.0) d = -d;
            if (d < bestd || (d == bestd && c % 2 == 0)) begin
                bestd = d;
                best  = 8'(c);
            end
        end
        return {r < 0.0, best[6:0]};
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] g = '0;
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) begin
                g[(last + k) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always begin
        logic [N-1:0] exp_rdy;
        int id;
        @(negedge clock);
        #2;
        cyc++;
        if (!reset_n) begin
            check("reset_req_ready", 32'(req_ready), 32'h0);
            check("reset_resp_valid", 32'(resp_valid), 32'h0);
            check("reset_resp_data", 32'(resp_data), 32'h0);
            check("reset_resp_id", 32'(resp_id), 32'h0);
            exp_q.delete();
            due_q.delete();
            model_busy = 1'b0;
            model_last = N - 1;
            hs_mask    = '0;
            prev_rv    = 1'b0;
            stat_exp   = 16'h0000;
        end else begin
            exp_rdy = model_busy ? '0 : rr_pick(req_valid, model_last);
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            hs_mask = req_valid & exp_rdy;
            if (hs_mask != '0) begin
                id = 0;
                for (int i = 0; i < N; i++) if (hs_mask[i]) id = i;
                exp_q.push_back({IDW'(id), ref_add(req_a[8*id +: 8], req_b[8*id +: 8])});
                due_q.push_back(cyc + LAT + 1);
                grant_log.push_back(id);
                model_busy = 1'b1;
                model_last = id;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'h0);
                end else begin
                    if (!prev_rv) check("resp_latency", 32'(cyc), 32'(due_q[0]));
                    check("resp_payload", 32'({resp_id, resp_data}), 32'(exp_q[0]));
                    if (resp_ready) begin
                        resp_log.push_back(exp_q.pop_front());
                        void'(due_q.pop_front());
                        model_busy = 1'b0;
                        if (stat_exp != 16'hFFFF) stat_exp = stat_exp + 16'h0001;
                    end
                end
            end else if (due_q.size() > 0 && cyc == due_q[0]) begin
                check("resp_missing", 32'(resp_valid), 32'h1);
            end
            prev_rv = resp_valid && !resp_ready;
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] specials [8] = '{8'h00, 8'h80, 8'h7E, 8'hFE, 8'h7F, 8'h01, 8'h08, 8'h38};

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 3))
            0, 1:    return 8'($urandom);
            2:       return specials[$urandom_range(0, 7)];
            default: return {1'($urandom), 4'($urandom_range(0, 3)), 3'($urandom)};
        endcase
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_grant(input int i);
        logic got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (hs_mask[i]) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_timeout", 32'(got), 32'h1);
    endtask

    task automatic wait_resp(input int n);
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (resp_log.size() >= n) break;
        end
        check("resp_timeout", 32'(resp_log.size() >= n), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        req_valid = '0;
        @(negedge clock);
        reset_n   = 1'b1;
    endtask

    task automatic rand_cycle();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !hs_mask[i]) begin
                if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                set_req(i, rand_op(), rand_op());
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gsz, rsz;
        logic [7:0] pa [4] = '{8'h40, 8'h28, 8'h50, 8'h40};
        logic [7:0] pb [4] = '{8'h40, 8'h10, 8'h10, 8'h40};
        logic [IDW+7:0] rr_exp [4] = '{10'h048, 10'h129, 10'h250, 10'h348};

        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Asynchronous reset asserted mid-cycle with every requester valid.
        @(negedge clock);
        for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_req_ready", 32'(req_ready), 32'h0);
        check("async_resp_valid", 32'(resp_valid), 32'h0);
        check("async_resp_data", 32'(resp_data), 32'h0);
        check("async_resp_id", 32'(resp_id), 32'h0);
        @(negedge clock);
        req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;

        // Single request from requester 2.
        rsz = resp_log.size();
        @(negedge clock);
        resp_ready = 1'b1;
        set_req(2, 8'h40, 8'h40);
        wait_grant(2);
        req_valid[2] = 1'b0;
        wait_resp(rsz + 1);
        if (resp_log.size() > rsz) check("single_result", 32'(resp_log[rsz]), 32'h248);

        // Rotation after reset: all four held until granted.
        do_reset();
        grant_log.delete();
        resp_log.delete();
        @(negedge clock);
        for (int i = 0; i < N; i++) set_req(i, pa[i], pb[i]);
        for (int k = 0; k < 80 && req_valid != '0; k++) begin
            @(negedge clock);
            req_valid = req_valid & ~hs_mask;
        end
        wait_resp(4);
        check("rr_grants", 32'(grant_log.size()), 32'h4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("rr_order", 32'(grant_log[i]), 32'(i));
        for (int i = 0; i < 4 && i < resp_log.size(); i++) check("rr_result", 32'(resp_log[i]), 32'(rr_exp[i]));
        set_req(0, rand_op(), rand_op());
        wait_grant(0);
        req_valid[0] = 1'b0;
        if (grant_log.size() > 4) check("rr_regrant", 32'(grant_log[4]), 32'h0);

        // Backpressure: response held while requester 3 waits.
        @(negedge clock);
        while (model_busy) @(negedge clock);
        resp_ready = 1'b0;
        rsz = resp_log.size();
        set_req(1, rand_op(), rand_op());
        set_req(3, rand_op(), rand_op());
        wait_grant(1);
        req_valid[1] = 1'b0;
        repeat (LAT + 5) @(negedge clock);
        check("bp_held_count", 32'(resp_log.size()), 32'(rsz));
        resp_ready = 1'b1;
        wait_grant(3);
        req_valid[3] = 1'b0;
        wait_resp(rsz + 2);

        // Reset during the second WAIT cycle drops the op.
        set_req(3, rand_op(), rand_op());
        wait_grant(3);
        req_valid[3] = 1'b0;
        rsz = resp_log.size();
        @(negedge clock);
        reset_n = 1'b0;
        #4;
        reset_n = 1'b1;
        gsz = grant_log.size();
        @(negedge clock);
        set_req(1, rand_op(), rand_op());
        set_req(0, rand_op(), rand_op());
        wait_grant(0);
        req_valid[0] = 1'b0;
        wait_grant(1);
        req_valid[1] = 1'b0;
        wait_resp(rsz + 2);
        if (grant_log.size() > gsz) check("post_reset_grant", 32'(grant_log[gsz]), 32'h0);
        check("dropped_op", 32'(resp_log.size()), 32'(rsz + 2));

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            rand_cycle();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || model_busy); k++) @(negedge clock);
        check("drain", 32'(exp_q.size()), 32'h0);

`ifdef FADD_ARB_STATS_EN
        #3;
        check("op_count", 32'(op_count), 32'(stat_exp));
        @(negedge clock);
        force dut.op_count = 16'hFFFE;
        stat_exp = 16'hFFFE;
        @(negedge clock);
        release dut.op_count;
        for (int n = 0; n < 3; n++) begin
            set_req(0, rand_op(), rand_op());
            wait_grant(0);
            req_valid[0] = 1'b0;
            while (model_busy) @(negedge clock);
        end
        #3;
        check("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
